// File: rtl/aes_pkg.sv
// Shared AES constants: state geometry, SubBytes FSM encoding and the forward/inverse S-box tables.
package aes_pkg;

  localparam int unsigned AES_STATE_W = 128;
  localparam int unsigned AES_BYTES   = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } sbe_state_e;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [0:255] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
    8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
    8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
    8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
    8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
    8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
    8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
    8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
    8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
    8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
    8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
    8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
    8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
    8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
    8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
    8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
    8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/sbox_lane.sv
// One combinational S-box lane: forward or inverse byte substitution by table lookup.
module sbox_lane
  import aes_pkg::*;
(
  input  logic [7:0] byte_i,
  input  logic       inverse_i,
  output logic [7:0] byte_o
);

  assign byte_o = inverse_i ? INV_SBOX[byte_i] : SBOX[byte_i];

endmodule

// File: rtl/sub_bytes_engine.sv
// Iterative AES SubBytes: substitutes NUM_SBOX bytes of a latched 128-bit state per RUN cycle.
module sub_bytes_engine
  import aes_pkg::*;
#(
  parameter int unsigned NUM_SBOX = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [0:AES_STATE_W-1] in_vector,
  input  logic                   in_inverse,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [0:AES_STATE_W-1] out_vector,
  output logic                   busy
);

  localparam int unsigned GROUPS = (NUM_SBOX == 0) ? 1 : AES_BYTES / NUM_SBOX;
  localparam int unsigned CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  if (NUM_SBOX != 1 && NUM_SBOX != 2 && NUM_SBOX != 4 && NUM_SBOX != 8 && NUM_SBOX != 16)
  begin : gen_bad_num_sbox
    $error("sub_bytes_engine: NUM_SBOX must be 1, 2, 4, 8 or 16");
  end

  sbe_state_e             state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [0:AES_STATE_W-1] data_q;
  logic                   mode_q;
  logic                   out_valid_q;
  logic                   busy_q;

  logic [3:0]                     grp_base;
  logic [NUM_SBOX-1:0][3:0]       lane_idx;
  logic [NUM_SBOX-1:0][7:0]       lane_in;
  logic [NUM_SBOX-1:0][7:0]       lane_out;

  // First byte index of the group currently being substituted.
  assign grp_base = 4'(32'(cnt_q) * NUM_SBOX);

  always_comb begin
    lane_idx = '0;
    lane_in  = '0;
    for (int l = 0; l < NUM_SBOX; l++) begin
      lane_idx[l] = grp_base + 4'(l);
      lane_in[l]  = data_q[{lane_idx[l], 3'b000} +: 8];
    end
  end

  for (genvar l = 0; l < NUM_SBOX; l++) begin : gen_lane
    sbox_lane u_sbox_lane (
      .byte_i    (lane_in[l]),
      .inverse_i (mode_q),
      .byte_o    (lane_out[l])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      data_q      <= '0;
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            data_q  <= in_vector;
            mode_q  <= in_inverse;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          for (int l = 0; l < NUM_SBOX; l++) begin
            data_q[{lane_idx[l], 3'b000} +: 8] <= lane_out[l];
          end
          if (cnt_q == CNT_W'(GROUPS - 1)) begin
            cnt_q       <= '0;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Gated by rst so the engine never advertises readiness while held in reset.
  assign in_ready   = (state_q == StIdle) && !rst;
  assign out_valid  = out_valid_q;
  assign out_vector = data_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Bench for sub_bytes_engine: one instance per legal NUM_SBOX, checked against a GF(2^8) model.
module tb_sub_bytes_engine;

  localparam int NINST = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] in_vector;
  logic         in_inverse;
  logic         in_valid_a   [NINST];
  logic         out_ready_a  [NINST];
  logic         in_ready_a   [NINST];
  logic         out_valid_a  [NINST];
  logic         busy_a       [NINST];
  logic [127:0] out_vector_a [NINST];

  int errors = 0;
  int checks = 0;

  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];

  localparam logic [127:0] FIPS_IN  = 128'h193de3be_a0f4e22b_9ac68d2a_e9f84808;
  localparam logic [127:0] FIPS_OUT = 128'hd42711ae_e0bf98f1_b8b45de5_1e415230;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NINST; g++) begin : gen_dut
    sub_bytes_engine #(.NUM_SBOX(1 << g)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid_a[g]),
      .in_ready   (in_ready_a[g]),
      .in_vector  (in_vector),
      .in_inverse (in_inverse),
      .out_valid  (out_valid_a[g]),
      .out_ready  (out_ready_a[g]),
      .out_vector (out_vector_a[g]),
      .busy       (busy_a[g])
    );
  end

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a = a_in;
    logic [7:0] b = b_in;
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int k);
    logic [7:0] r;
    r = (x << k) | (x >> (8 - k));
    return r;
  endfunction

  // S(x) = affine(x^-1) in GF(2^8), with 0 mapped to 0 before the affine step.
  function automatic logic [7:0] sbox_model(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    for (int y = 1; y < 256; y++) begin
      if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    end
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_ref(input logic [127:0] v, input logic inv);
    logic [127:0] r;
    logic [7:0]   b;
    for (int i = 0; i < 16; i++) begin
      b = v[127 - 8 * i -: 8];
      r[127 - 8 * i -: 8] = inv ? inv_tab[b] : fwd_tab[b];
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one block to instance g, check latency, result and handshake back to IDLE.
  task automatic run_block(input int g, input logic [127:0] v, input logic inv,
                           input logic [127:0] exp, input string tag);
    int lat;
    check({tag, "/ready_before"}, 128'(in_ready_a[g]), 128'd1);
    in_vector     = v;
    in_inverse    = inv;
    in_valid_a[g] = 1'b1;
    step();
    in_valid_a[g] = 1'b0;
    in_vector     = {$urandom(), $urandom(), $urandom(), $urandom()};
    in_inverse    = ~inv;
    check({tag, "/busy_run"}, 128'(busy_a[g]), 128'd1);
    check({tag, "/ready_run"}, 128'(in_ready_a[g]), 128'd0);
    lat = 0;
    while (!out_valid_a[g] && lat < 40) begin
      step();
      lat++;
    end
    check({tag, "/latency"}, 128'(lat), 128'(16 >> g));
    check({tag, "/out_valid"}, 128'(out_valid_a[g]), 128'd1);
    check({tag, "/out_vector"}, out_vector_a[g], exp);
    out_ready_a[g] = 1'b1;
    step();
    out_ready_a[g] = 1'b0;
    check({tag, "/valid_drop"}, 128'(out_valid_a[g]), 128'd0);
    check({tag, "/ready_after"}, 128'(in_ready_a[g]), 128'd1);
    check({tag, "/busy_after"}, 128'(busy_a[g]), 128'd0);
  endtask

  initial begin
    logic [127:0] v, exp, held, orig;
    logic         inv;
    int           g, lat, idx, nres;
    logic         acc_next;
    int           acc_cyc [3];
    logic [127:0] b2b_v   [3];
    logic         b2b_m   [3];
    logic [127:0] got     [3];

    for (int i = 0; i < 256; i++) fwd_tab[i] = sbox_model(8'(i));
    for (int i = 0; i < 256; i++) inv_tab[fwd_tab[i]] = 8'(i);

    rst        = 1'b1;
    in_vector  = '0;
    in_inverse = 1'b0;
    for (int i = 0; i < NINST; i++) begin
      in_valid_a[i]  = 1'b0;
      out_ready_a[i] = 1'b0;
    end
    repeat (2) step();

    // Reset state
    check("rst/in_ready", 128'(in_ready_a[0]), 128'd0);
    check("rst/out_valid", 128'(out_valid_a[0]), 128'd0);
    check("rst/busy", 128'(busy_a[0]), 128'd0);
    check("rst/out_vector", out_vector_a[0], 128'd0);
    check("rst/in_ready4", 128'(in_ready_a[4]), 128'd0);
    rst = 1'b0;
    #1;
    check("rel/in_ready", 128'(in_ready_a[0]), 128'd1);
    step();

    // FIPS-197 forward on every lane count
    for (int i = 0; i < NINST; i++) begin
      run_block(i, FIPS_IN, 1'b0, FIPS_OUT, $sformatf("fips_fwd_n%0d", 1 << i));
    end

    run_block(2, FIPS_OUT, 1'b1, FIPS_IN, "fips_inv");
    run_block(2, {16{8'h00}}, 1'b0, {16{8'h63}}, "all00");
    run_block(2, {16{8'hff}}, 1'b0, {16{8'h16}}, "allff");
    run_block(2, {16{8'h53}}, 1'b0, {16{8'hed}}, "all53");
    run_block(2, {16{8'hed}}, 1'b1, {16{8'h53}}, "rt53");
    run_block(3, {16{8'h63}}, 1'b1, {16{8'h00}}, "rt00");

    // Random blocks on random instances, plus round trip
    for (int k = 0; k < 6; k++) begin
      g    = $urandom_range(0, NINST - 1);
      v    = {$urandom(), $urandom(), $urandom(), $urandom()};
      inv  = 1'($urandom_range(0, 1));
      exp  = sub_ref(v, inv);
      run_block(g, v, inv, exp, $sformatf("rand%0d_n%0d", k, 1 << g));
      run_block(g, exp, ~inv, v, $sformatf("rand%0d_rt", k));
    end

    // Backpressure on NUM_SBOX=4
    orig          = {$urandom(), $urandom(), $urandom(), $urandom()};
    exp           = sub_ref(orig, 1'b0);
    in_vector     = orig;
    in_inverse    = 1'b0;
    in_valid_a[2] = 1'b1;
    step();
    in_valid_a[2] = 1'b0;
    lat = 0;
    while (!out_valid_a[2] && lat < 40) begin
      step();
      lat++;
    end
    check("bp/latency", 128'(lat), 128'd4);
    held = exp;
    for (int c = 0; c < 5; c++) begin
      in_valid_a[2] = (c == 2);
      in_inverse    = (c == 3);
      in_vector     = ~orig;
      check($sformatf("bp/vec%0d", c), out_vector_a[2], held);
      check($sformatf("bp/ready%0d", c), 128'(in_ready_a[2]), 128'd0);
      check($sformatf("bp/busy%0d", c), 128'(busy_a[2]), 128'd1);
      check($sformatf("bp/valid%0d", c), 128'(out_valid_a[2]), 128'd1);
      step();
    end
    in_valid_a[2]  = 1'b0;
    check("bp/vec_final", out_vector_a[2], held);
    out_ready_a[2] = 1'b1;
    step();
    out_ready_a[2] = 1'b0;
    check("bp/valid_drop", 128'(out_valid_a[2]), 128'd0);
    check("bp/ready_back", 128'(in_ready_a[2]), 128'd1);
    step();
    check("bp/no_second", 128'(busy_a[2]), 128'd0);
    check("bp/ready_idle", 128'(in_ready_a[2]), 128'd1);

    // Reset in the middle of RUN on NUM_SBOX=1
    in_vector     = FIPS_IN;
    in_inverse    = 1'b0;
    in_valid_a[0] = 1'b1;
    step();
    in_valid_a[0] = 1'b0;
    repeat (7) step();
    check("midrst/busy_pre", 128'(busy_a[0]), 128'd1);
    rst = 1'b1;
    #1;
    check("midrst/out_valid", 128'(out_valid_a[0]), 128'd0);
    check("midrst/busy", 128'(busy_a[0]), 128'd0);
    check("midrst/out_vector", out_vector_a[0], 128'd0);
    check("midrst/in_ready", 128'(in_ready_a[0]), 128'd0);
    #1;
    rst = 1'b0;
    step();
    run_block(0, FIPS_IN, 1'b0, FIPS_OUT, "midrst/fresh");

    // Back-to-back, alternating modes, out_ready tied high on NUM_SBOX=4
    b2b_v[0] = FIPS_IN;
    b2b_m[0] = 1'b0;
    b2b_v[1] = FIPS_OUT;
    b2b_m[1] = 1'b1;
    b2b_v[2] = {$urandom(), $urandom(), $urandom(), $urandom()};
    b2b_m[2] = 1'b0;
    idx  = 0;
    nres = 0;
    out_ready_a[2] = 1'b1;
    in_vector      = b2b_v[0];
    in_inverse     = b2b_m[0];
    in_valid_a[2]  = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      acc_next = in_ready_a[2] && in_valid_a[2];
      if (out_valid_a[2] && nres < 3) begin
        got[nres] = out_vector_a[2];
        nres++;
      end
      step();
      if (acc_next && idx < 3) begin
        acc_cyc[idx] = cyc;
        idx++;
        if (idx < 3) begin
          in_vector  = b2b_v[idx];
          in_inverse = b2b_m[idx];
        end else begin
          in_valid_a[2] = 1'b0;
        end
      end
      if (nres == 3) break;
    end
    in_valid_a[2] = 1'b0;
    check("b2b/accepts", 128'(idx), 128'd3);
    check("b2b/results", 128'(nres), 128'd3);
    if (idx == 3) begin
      check("b2b/spacing01", 128'(acc_cyc[1] - acc_cyc[0]), 128'd6);
      check("b2b/spacing12", 128'(acc_cyc[2] - acc_cyc[1]), 128'd6);
    end
    if (nres == 3) begin
      check("b2b/res0", got[0], FIPS_OUT);
      check("b2b/res1", got[1], FIPS_IN);
      check("b2b/res2", got[2], sub_ref(b2b_v[2], 1'b0));
    end
    step();
    out_ready_a[2] = 1'b0;
    check("b2b/idle_busy", 128'(busy_a[2]), 128'd0);
    check("b2b/idle_valid", 128'(out_valid_a[2]), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
